// File: rtl/reg_file_param.sv
// Parametrised register file: NUM_RD combinational read ports, one write port, and a
// sequential clear engine. Optional write-to-read bypass is enabled by REG_FILE_BYPASS_EN.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] addr_rs,
    output logic [NUM_RD*DATA_W-1:0] data_rs,
    input  logic [ADDR_W-1:0]        addr_rd,
    input  logic [DATA_W-1:0]        data_rd,
    input  logic                     write_enable,
    input  logic                     clear_req,
    output logic                     ready
);

    localparam int DEPTH = 2**ADDR_W;

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              write_ok;

    assign ready    = (state == RUN);
    assign write_ok = write_enable && !((ZERO_REG != 0) && (addr_rd == '0));

    // clr_cnt wraps to zero on its own as the last entry is cleared
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state   <= INIT;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= INIT;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    // The array has no reset; the clear engine is what makes its contents defined
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            mem[clr_cnt] <= '0;
        end else if (write_ok) begin
            mem[addr_rd] <= data_rd;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              zero_hit;
        logic              byp_hit;

        assign ra       = addr_rs[i*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);
`ifdef REG_FILE_BYPASS_EN
        assign byp_hit  = write_enable && (addr_rd == ra);
`else
        assign byp_hit  = 1'b0;
`endif

        assign data_rs[i*DATA_W +: DATA_W] = ((state != RUN) || zero_hit) ? '0 :
                                             byp_hit ? data_rd : mem[ra];
    end

endmodule
